// File: rtl/i2c_bus_mon_pkg.sv
// Shared types and constants for the I2C bus monitor slice.
package i2c_pkg;

  localparam int unsigned I2C_BITCNT_W = 4;
  localparam logic        I2C_ACK      = 1'b0;
  localparam logic        I2C_NACK     = 1'b1;

  typedef enum logic {
    IDLE,
    RX
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_mon_if.sv
// Bus-side signal bundle of the I2C monitor: raw synchronized inputs plus all monitor outputs.
interface i2c_bus_mon_if;

  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       start_o;
  logic       stop_o;
  logic       byte_vld_o;
  logic [7:0] byte_o;
  logic       ack_vld_o;
  logic       ack_o;
  logic       busy_o;
  logic       timeout_o;

  // slave: the monitor itself; master: whoever drives the lines and consumes the events
  modport slave (
    input  scl_i, sda_i,
    output scl_o, sda_o, start_o, stop_o, byte_vld_o, byte_o,
           ack_vld_o, ack_o, busy_o, timeout_o
  );

  modport master (
    output scl_i, sda_i,
    input  scl_o, sda_o, start_o, stop_o, byte_vld_o, byte_o,
           ack_vld_o, ack_o, busy_o, timeout_o
  );

endinterface

// File: rtl/i2c_glitch_filt.sv
// Per-line glitch filter: output follows the input only after FILT_G consecutive differing cycles.
module i2c_glitch_filt
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_G = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic       q_q, q_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    if (d_i != q_q) begin
      if (cnt_q == 8'(FILT_G - 1)) begin
        q_d = ~q_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= 1'b1;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/i2c_bus_mon.sv
// I2C bus-condition and bit-level receive monitor (START/STOP/byte/ACK strobes, busy flag).
// Optional SCL-low timeout enabled by defining I2C_BUS_MON_TIMEOUT_EN.
module i2c_bus_mon
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_G    = 4,
  parameter int unsigned TIMEOUT_G = 65535
) (
  input  logic           clk,
  input  logic           rst,
  i2c_bus_mon_if.slave   bus
);

  logic scl_f, sda_f;
  logic scl_p_q, sda_p_q;
  logic start_det, stop_det, scl_rise;
  logic tmo_hit;

  i2c_glitch_filt #(.FILT_G(FILT_G)) u_filt_scl (
    .clk (clk),
    .rst (rst),
    .d_i (bus.scl_i),
    .q_o (scl_f)
  );

  i2c_glitch_filt #(.FILT_G(FILT_G)) u_filt_sda (
    .clk (clk),
    .rst (rst),
    .d_i (bus.sda_i),
    .q_o (sda_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  // SCL must be high in both samples, so a simultaneous SCL/SDA change never counts
  assign start_det = scl_f & scl_p_q &  sda_p_q & ~sda_f;
  assign stop_det  = scl_f & scl_p_q & ~sda_p_q &  sda_f;
  assign scl_rise  = scl_f & ~scl_p_q;

  i2c_state_e              state_q, state_d;
  logic [I2C_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [6:0]              shift_q, shift_d;
  logic [7:0]              byte_q, byte_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    start_q, start_d;
  logic                    stop_q, stop_d;
  logic                    bvld_q, bvld_d;
  logic                    avld_q, avld_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    bvld_d   = 1'b0;
    avld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_det) begin
          state_d  = RX;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          start_d  = 1'b1;
        end else if (stop_det) begin
          stop_d = 1'b1;
        end
      end
      RX: begin
        if (stop_det) begin
          state_d  = IDLE;
          bitcnt_d = '0;
          busy_d   = 1'b0;
          stop_d   = 1'b1;
        end else if (start_det) begin
          bitcnt_d = '0;
          start_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          bitcnt_d = '0;
          busy_d   = 1'b0;
        end else if (scl_rise) begin
          if (bitcnt_q == I2C_BITCNT_W'(8)) begin
            ack_d    = sda_f;
            avld_d   = 1'b1;
            bitcnt_d = '0;
          end else begin
            shift_d  = {shift_q[5:0], sda_f};
            bitcnt_d = bitcnt_q + I2C_BITCNT_W'(1);
            if (bitcnt_q == I2C_BITCNT_W'(7)) begin
              byte_d = {shift_q, sda_f};
              bvld_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      byte_q   <= 8'h00;
      ack_q    <= I2C_NACK;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      bvld_q   <= 1'b0;
      avld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      bvld_q   <= bvld_d;
      avld_q   <= avld_d;
    end
  end

`ifdef I2C_BUS_MON_TIMEOUT_EN
  logic [19:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q;

  assign tmo_hit   = (state_q == RX) && !scl_f && (tmo_cnt_q == 20'(TIMEOUT_G - 1));
  assign tmo_cnt_d = ((state_q == RX) && !scl_f && !tmo_hit) ? tmo_cnt_q + 20'd1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= tmo_hit;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  logic [19:0] unused_timeout_g;
  assign unused_timeout_g = 20'(TIMEOUT_G);
  assign tmo_hit          = 1'b0;
  assign bus.timeout_o    = 1'b0;
`endif

  assign bus.scl_o      = scl_f;
  assign bus.sda_o      = sda_f;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.byte_vld_o = bvld_q;
  assign bus.byte_o     = byte_q;
  assign bus.ack_vld_o  = avld_q;
  assign bus.ack_o      = ack_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_bus_mon.sv
// Scoreboard bench for i2c_bus_mon with FILT_G = 2 and TIMEOUT_G = 50.
module tb_i2c_bus_mon;

  localparam int unsigned FILT = 2;
  localparam int unsigned TMO  = 50;

  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_STOP  = 3'd2;
  localparam logic [2:0] EV_BYTE  = 3'd3;
  localparam logic [2:0] EV_ACK   = 3'd4;
  localparam logic [2:0] EV_TMO   = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2c_bus_mon_if bus_if ();

  i2c_bus_mon #(.FILT_G(FILT), .TIMEOUT_G(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] t, input logic [7:0] d);
    exp_q.push_back({t, d});
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every observed strobe is matched against the next expected event
  int          mon_ns;
  logic [10:0] mon_obs;
  always @(negedge clk) begin
    if (!rst) begin
      mon_ns = int'(bus_if.start_o) + int'(bus_if.stop_o) + int'(bus_if.byte_vld_o)
             + int'(bus_if.ack_vld_o) + int'(bus_if.timeout_o);
      if (mon_ns != 0) begin
        chk("one_strobe", 32'(mon_ns > 1), 32'd0);
        if (bus_if.start_o)          mon_obs = {EV_START, 8'h00};
        else if (bus_if.stop_o)      mon_obs = {EV_STOP, 8'h00};
        else if (bus_if.byte_vld_o)  mon_obs = {EV_BYTE, bus_if.byte_o};
        else if (bus_if.ack_vld_o)   mon_obs = {EV_ACK, 7'd0, bus_if.ack_o};
        else                         mon_obs = {EV_TMO, 8'h00};
        if (exp_q.size() == 0) chk("unexpected_event", 32'(mon_obs), 32'd0);
        else                   chk("event", 32'(mon_obs), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_scl_o"}, 32'(bus_if.scl_o), 32'd1);
    chk({tag, "_sda_o"}, 32'(bus_if.sda_o), 32'd1);
    chk({tag, "_strobes"}, 32'({bus_if.start_o, bus_if.stop_o, bus_if.byte_vld_o,
                                bus_if.ack_vld_o, bus_if.timeout_o}), 32'd0);
    chk({tag, "_busy"}, 32'(bus_if.busy_o), 32'd0);
    chk({tag, "_byte"}, 32'(bus_if.byte_o), 32'h00);
    chk({tag, "_ack"}, 32'(bus_if.ack_o), 32'd1);
  endtask

  // requires SCL low on entry; SDA only changes while SCL is low
  task automatic send_bit(input logic b);
    bus_if.sda_i = b;  cyc(4);
    bus_if.scl_i = 1'b1; cyc(5);
    bus_if.scl_i = 1'b0; cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    push_ev(EV_BYTE, d);
    push_ev(EV_ACK, {7'd0, ack});
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(ack);
  endtask

  // requires idle lines (SCL=1, SDA=1); leaves SCL low
  task automatic do_start();
    push_ev(EV_START, 8'h00);
    bus_if.sda_i = 1'b0; cyc(4);
    bus_if.scl_i = 1'b0; cyc(4);
  endtask

  // requires SCL low; leaves lines idle
  task automatic do_stop();
    bus_if.sda_i = 1'b0; cyc(4);
    bus_if.scl_i = 1'b1; cyc(4);
    push_ev(EV_STOP, 8'h00);
    bus_if.sda_i = 1'b1; cyc(4);
  endtask

  initial begin
    bus_if.scl_i = 1'b1;
    bus_if.sda_i = 1'b1;
    rst = 1'b1;
    cyc(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc(5);

    // START latency: strobe exactly FILT+1 cycles after the SDA fall
    push_ev(EV_START, 8'h00);
    bus_if.sda_i = 1'b0;
    cyc(1); chk("start_lat_c1", 32'(bus_if.start_o), 32'd0);
    cyc(1); chk("start_lat_c2", 32'(bus_if.start_o), 32'd0);
    cyc(1); chk("start_lat_c3", 32'(bus_if.start_o), 32'd1);
    chk("busy_at_start", 32'(bus_if.busy_o), 32'd1);
    cyc(1); chk("start_lat_c4", 32'(bus_if.start_o), 32'd0);
    bus_if.scl_i = 1'b0; cyc(4);

    send_byte(8'hA5, 1'b0);
    chk("byte_hold_a5", 32'(bus_if.byte_o), 32'hA5);
    chk("ack_hold", 32'(bus_if.ack_o), 32'd0);

    // repeated START after 3 bits discards the partial byte
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    bus_if.sda_i = 1'b1; cyc(4);
    bus_if.scl_i = 1'b1; cyc(4);
    push_ev(EV_START, 8'h00);
    bus_if.sda_i = 1'b0; cyc(4);
    chk("busy_rep_start", 32'(bus_if.busy_o), 32'd1);
    bus_if.scl_i = 1'b0; cyc(4);
    send_byte(8'h3C, 1'b1);
    chk("byte_hold_3c", 32'(bus_if.byte_o), 32'h3C);
    chk("nack_hold", 32'(bus_if.ack_o), 32'd1);

    // STOP mid-byte, then SCL activity in IDLE must stay silent
    send_bit(1'b0); send_bit(1'b1);
    do_stop();
    chk("busy_after_stop", 32'(bus_if.busy_o), 32'd0);
    bus_if.scl_i = 1'b0; cyc(4);
    for (int i = 0; i < 9; i++) send_bit(i[0]);
    bus_if.sda_i = 1'b1; cyc(4);
    bus_if.scl_i = 1'b1; cyc(6);
    chk("byte_after_idle", 32'(bus_if.byte_o), 32'h3C);

    // glitch filter: 1-cycle SDA pulse suppressed, 2-cycle pulse gives START then STOP
    bus_if.sda_i = 1'b0; cyc(1);
    bus_if.sda_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("glitch_sda_o", 32'(bus_if.sda_o), 32'd1);
      cyc(1);
    end
    push_ev(EV_START, 8'h00);
    push_ev(EV_STOP, 8'h00);
    bus_if.sda_i = 1'b0; cyc(2);
    bus_if.sda_i = 1'b1; cyc(8);
    chk("busy_after_pulse", 32'(bus_if.busy_o), 32'd0);

    // reset mid-byte
    do_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    bus_if.scl_i = 1'b1;
    bus_if.sda_i = 1'b1;
    cyc(1);
    chk_reset_vals("midrst");
    rst = 1'b0;
    cyc(8);
    chk("busy_after_rst", 32'(bus_if.busy_o), 32'd0);

    // SCL held low after START
    do_start();
`ifdef I2C_BUS_MON_TIMEOUT_EN
    push_ev(EV_TMO, 8'h00);
    cyc(60);
    chk("busy_after_tmo", 32'(bus_if.busy_o), 32'd0);
`else
    cyc(60);
    chk("busy_no_tmo", 32'(bus_if.busy_o), 32'd1);
`endif
    do_stop();
    cyc(10);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
